// File: rtl/exe_stage.sv
// Execute stage: operand select, ALU, iterative divider, data SRAM request,
// result handoff to mem stage and forward/stall info back to decode.
module exe_stage #(
  parameter int DS_TO_ES_BUS_WD = 153,
  parameter int ES_TO_MS_BUS_WD = 72,
  parameter int ES_TO_DS_BUS_WD = 39
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ms_allowin,
  output logic                       es_allowin,
  input  logic                       ds_to_es_valid,
  input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
  output logic                       es_to_ms_valid,
  output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic [ES_TO_DS_BUS_WD-1:0] es_to_ds_forward_bus,
  output logic                       es_to_ds_valid,
  output logic                       data_sram_en,
  output logic [3:0]                 data_sram_we,
  output logic [31:0]                data_sram_addr,
  output logic [31:0]                data_sram_wdata
);

  typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, DONE = 2'b10} div_state_t;

  logic                       es_valid;
  logic                       es_ready_go;
  logic [DS_TO_ES_BUS_WD-1:0] bus_r;

  // decoded fields of the resident instruction
  logic [11:0] alu_op;
  logic [1:0]  div_op;
  logic        div_signed, load_op, store_op, src1_is_pc, src2_is_imm, gr_we;
  logic [4:0]  dest;
  logic [31:0] imm, rj_value, rkd_value, pc;

  assign {alu_op, div_op, div_signed, load_op, store_op, src1_is_pc, src2_is_imm,
          gr_we, dest, imm, rj_value, rkd_value, pc} = bus_r;

  logic [31:0] src1, src2;
  assign src1 = src1_is_pc  ? pc  : rj_value;
  assign src2 = src2_is_imm ? imm : rkd_value;

  // ---------------- ALU ----------------
  logic [31:0] add_res, sub_res, sll_res, srl_res, sra_res, alu_result;
  logic        slt_res, sltu_res;

  assign add_res  = src1 + src2;
  assign sub_res  = src1 - src2;
  assign slt_res  = $signed(src1) < $signed(src2);
  assign sltu_res = src1 < src2;
  assign sll_res  = src1 << src2[4:0];
  assign srl_res  = src1 >> src2[4:0];
  assign sra_res  = $unsigned($signed(src1) >>> src2[4:0]);

  // AND-OR mux so an all-zero alu_op yields zero
  assign alu_result = ({32{alu_op[0]}}  & add_res)
                    | ({32{alu_op[1]}}  & sub_res)
                    | ({32{alu_op[2]}}  & {31'd0, slt_res})
                    | ({32{alu_op[3]}}  & {31'd0, sltu_res})
                    | ({32{alu_op[4]}}  & (src1 & src2))
                    | ({32{alu_op[5]}}  & ~(src1 | src2))
                    | ({32{alu_op[6]}}  & (src1 | src2))
                    | ({32{alu_op[7]}}  & (src1 ^ src2))
                    | ({32{alu_op[8]}}  & sll_res)
                    | ({32{alu_op[9]}}  & srl_res)
                    | ({32{alu_op[10]}} & sra_res)
                    | ({32{alu_op[11]}} & src2);

  // ---------------- divider ----------------
  div_state_t  div_state;
  logic [4:0]  div_cnt;
  logic [31:0] div_rem, div_quo, div_dvs;
  logic [31:0] abs1, abs2;
  logic [32:0] div_shift, div_diff;
  logic        div_ge, is_div;

  assign is_div = |div_op;
  assign abs1   = (div_signed & src1[31]) ? -src1 : src1;
  assign abs2   = (div_signed & src2[31]) ? -src2 : src2;

  // one restoring step: shift next dividend bit into the partial remainder
  assign div_shift = {div_rem, div_quo[31]};
  assign div_diff  = div_shift - {1'b0, div_dvs};
  assign div_ge    = ~div_diff[32];

  // divider FSM: latch magnitudes, 32 quotient-bit steps, hold until handoff
  always_ff @(posedge clk) begin
    if (reset) begin
      div_state <= IDLE;
      div_cnt   <= 5'd0;
      div_rem   <= 32'd0;
      div_quo   <= 32'd0;
      div_dvs   <= 32'd0;
    end else begin
      case (div_state)
        IDLE: if (es_valid & is_div) begin
          div_state <= BUSY;
          div_cnt   <= 5'd0;
          div_rem   <= 32'd0;
          div_quo   <= abs1;
          div_dvs   <= abs2;
        end
        BUSY: begin
          div_rem <= div_ge ? div_diff[31:0] : div_shift[31:0];
          div_quo <= {div_quo[30:0], div_ge};
          div_cnt <= div_cnt + 5'd1;
          if (div_cnt == 5'd31) div_state <= DONE;
        end
        DONE: if (es_ready_go & ms_allowin) div_state <= IDLE;
        default: div_state <= IDLE;
      endcase
    end
  end

  logic        q_neg, r_neg, dvs_zero;
  logic [31:0] quotient, remainder, exe_result;

  assign q_neg     = div_signed & (src1[31] ^ src2[31]);
  assign r_neg     = div_signed & src1[31];
  assign dvs_zero  = (src2 == 32'd0);
  assign quotient  = dvs_zero ? 32'hFFFF_FFFF : (q_neg ? -div_quo : div_quo);
  assign remainder = dvs_zero ? src1          : (r_neg ? -div_rem : div_rem);
  assign exe_result = div_op[1] ? quotient : (div_op[0] ? remainder : alu_result);

  // ---------------- handshake ----------------
  assign es_ready_go    = ~is_div | (div_state == DONE);
  assign es_allowin     = ~es_valid | (es_ready_go & ms_allowin);
  assign es_to_ms_valid = es_valid & es_ready_go;
  assign es_to_ds_valid = es_valid;

  // stage valid bit
  always_ff @(posedge clk) begin
    if (reset)           es_valid <= 1'b0;
    else if (es_allowin) es_valid <= ds_to_es_valid;
  end

  // instruction register, loaded only on an accepted transfer
  always_ff @(posedge clk) begin
    if (reset)                            bus_r <= '0;
    else if (ds_to_es_valid & es_allowin) bus_r <= ds_to_es_bus;
  end

  assign es_to_ms_bus = {store_op, load_op, gr_we, dest, exe_result, pc};

  // ---------------- memory request ----------------
  assign data_sram_en    = es_valid & es_ready_go & ms_allowin & (load_op | store_op);
  assign data_sram_we    = {4{data_sram_en & store_op}};
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = rkd_value;

  // ---------------- forwarding ----------------
  logic forward_enable, dep_need_stall;
  assign forward_enable = es_valid & gr_we & (dest != 5'd0);
  assign dep_need_stall = load_op | (is_div & (div_state != DONE));
  assign es_to_ds_forward_bus = {dep_need_stall, forward_enable, dest, exe_result};

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: ALU ops, store/load requests, backpressure,
// divider latency and results, and reset during a divide.
module tb_exe_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         ms_allowin;
  logic         es_allowin;
  logic         ds_to_es_valid;
  logic [152:0] ds_to_es_bus;
  logic         es_to_ms_valid;
  logic [71:0]  es_to_ms_bus;
  logic [38:0]  es_to_ds_forward_bus;
  logic         es_to_ds_valid;
  logic         data_sram_en;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;

  int checks = 0;
  int errors = 0;

  exe_stage dut (
    .clk(clk), .reset(reset), .ms_allowin(ms_allowin), .es_allowin(es_allowin),
    .ds_to_es_valid(ds_to_es_valid), .ds_to_es_bus(ds_to_es_bus),
    .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
    .es_to_ds_forward_bus(es_to_ds_forward_bus), .es_to_ds_valid(es_to_ds_valid),
    .data_sram_en(data_sram_en), .data_sram_we(data_sram_we),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata)
  );

  always #5 clk = ~clk;

  localparam logic [11:0] OP_ADD = 12'h001;
  localparam logic [11:0] OP_SRA = 12'h400;
  localparam logic [11:0] OP_LUI = 12'h800;

  function automatic logic [152:0] mk(input logic [11:0] alu, input logic [1:0] dop,
                                      input logic sgn, input logic ld, input logic st,
                                      input logic s1pc, input logic s2imm, input logic we,
                                      input logic [4:0] dst, input logic [31:0] im,
                                      input logic [31:0] rj, input logic [31:0] rk,
                                      input logic [31:0] pcv);
    return {alu, dop, sgn, ld, st, s1pc, s2imm, we, dst, im, rj, rk, pcv};
  endfunction

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // present one instruction for one edge; returns #1 after it is accepted
  task automatic issue(input logic [152:0] b);
    ds_to_es_valid = 1'b1;
    ds_to_es_bus   = b;
    @(posedge clk); #1;
    ds_to_es_valid = 1'b0;
  endtask

  // issue a divide, wait (bounded) for the result, check latency and value
  task automatic div_run(input logic [152:0] b, input logic [31:0] exp, input string tag,
                         input bit chk_stall);
    int n;
    issue(b);
    n = 1;
    while (!es_to_ms_valid && n < 40) begin
      if (chk_stall) chk({tag, "_stall"}, es_to_ds_forward_bus[38], 1'b1);
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, n, 34);
    chk({tag, "_result"}, es_to_ms_bus[63:32], exp);
    if (chk_stall) chk({tag, "_stall_done"}, es_to_ds_forward_bus[38], 1'b0);
  endtask

  initial begin
    reset = 1'b1; ms_allowin = 1'b1; ds_to_es_valid = 1'b0; ds_to_es_bus = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_es_valid", es_to_ds_valid, 1'b0);
    chk("rst_ms_valid", es_to_ms_valid, 1'b0);
    chk("rst_en", data_sram_en, 1'b0);
    chk("rst_we", data_sram_we, 4'h0);
    chk("rst_state", dut.div_state, 2'b00);
    chk("rst_cnt", dut.div_cnt, 5'd0);
    reset = 1'b0;

    // add 5 + 0xFFFFFFFF -> 4
    issue(mk(OP_ADD, 2'b00, 0, 0, 0, 0, 0, 1, 5'd3, 32'd0, 32'd5, 32'hFFFF_FFFF, 32'h1C00_0000));
    chk("add_valid", es_to_ms_valid, 1'b1);
    chk("add_result", es_to_ms_bus[63:32], 32'd4);
    chk("add_gr_we", es_to_ms_bus[69], 1'b1);
    chk("add_fwd_en", es_to_ds_forward_bus[37], 1'b1);
    chk("add_fwd_dest", es_to_ds_forward_bus[36:32], 5'd3);
    chk("add_en", data_sram_en, 1'b0);

    // lui, sra
    issue(mk(OP_LUI, 2'b00, 0, 0, 0, 0, 1, 1, 5'd4, 32'h1234_5000, 32'h0, 32'h0, 32'h1C00_0004));
    chk("lui_result", es_to_ms_bus[63:32], 32'h1234_5000);
    issue(mk(OP_SRA, 2'b00, 0, 0, 0, 0, 0, 1, 5'd6, 32'h0, 32'h8000_0000, 32'd4, 32'h1C00_0008));
    chk("sra_result", es_to_ms_bus[63:32], 32'hF800_0000);

    // store 0xDEADBEEF to 0x100+8
    issue(mk(OP_ADD, 2'b00, 0, 0, 1, 0, 1, 0, 5'd0, 32'd8, 32'h100, 32'hDEAD_BEEF, 32'h1C00_000C));
    chk("st_en", data_sram_en, 1'b1);
    chk("st_we", data_sram_we, 4'hF);
    chk("st_addr", data_sram_addr, 32'h108);
    chk("st_wdata", data_sram_wdata, 32'hDEAD_BEEF);
    chk("st_fwd_en", es_to_ds_forward_bus[37], 1'b0);
    @(posedge clk); #1;
    chk("st_en_after", data_sram_en, 1'b0);
    chk("st_we_after", data_sram_we, 4'h0);

    // load held by backpressure
    ms_allowin = 1'b0;
    issue(mk(OP_ADD, 2'b00, 0, 1, 0, 0, 1, 1, 5'd5, 32'd4, 32'h200, 32'h0, 32'h1C00_0010));
    chk("bp_en", data_sram_en, 1'b0);
    chk("bp_allowin", es_allowin, 1'b0);
    chk("bp_stall", es_to_ds_forward_bus[38], 1'b1);
    @(posedge clk); #1;
    chk("bp_bus_stable", es_to_ms_bus, {1'b0, 1'b1, 1'b1, 5'd5, 32'h204, 32'h1C00_0010});
    chk("bp_en_hold", data_sram_en, 1'b0);
    ms_allowin = 1'b1;
    #1;
    chk("bp_en_release", data_sram_en, 1'b1);
    chk("bp_we_release", data_sram_we, 4'h0);
    chk("bp_addr", data_sram_addr, 32'h204);
    @(posedge clk); #1;
    chk("bp_en_after", data_sram_en, 1'b0);
    chk("bp_valid_after", es_to_ms_valid, 1'b0);

    // signed divide / modulo
    div_run(mk(12'h0, 2'b10, 1, 0, 0, 0, 0, 1, 5'd7, 32'h0, 32'hFFFF_FFF9, 32'd2, 32'h1C00_0014), 32'hFFFF_FFFD, "sdiv", 1'b1);
    div_run(mk(12'h0, 2'b01, 1, 0, 0, 0, 0, 1, 5'd7, 32'h0, 32'hFFFF_FFF9, 32'd2, 32'h1C00_0018), 32'hFFFF_FFFF, "smod", 1'b0);
    div_run(mk(12'h0, 2'b10, 1, 0, 0, 0, 0, 1, 5'd8, 32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1C00_001C), 32'h8000_0000, "ovf_div", 1'b0);
    div_run(mk(12'h0, 2'b01, 1, 0, 0, 0, 0, 1, 5'd8, 32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1C00_0020), 32'h0, "ovf_mod", 1'b0);

    // divide by zero, unsigned
    div_run(mk(12'h0, 2'b10, 0, 0, 0, 0, 0, 1, 5'd9, 32'h0, 32'd9, 32'd0, 32'h1C00_0024), 32'hFFFF_FFFF, "div0", 1'b0);
    div_run(mk(12'h0, 2'b01, 0, 0, 0, 0, 0, 1, 5'd9, 32'h0, 32'd9, 32'd0, 32'h1C00_0028), 32'd9, "mod0", 1'b0);

    // reset while the divider is at count 10
    issue(mk(12'h0, 2'b10, 0, 0, 0, 0, 0, 1, 5'd10, 32'h0, 32'd100, 32'd3, 32'h1C00_002C));
    repeat (11) begin @(posedge clk); #1; end
    chk("mid_state", dut.div_state, 2'b01);
    chk("mid_cnt", dut.div_cnt, 5'd10);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_es_valid", es_to_ds_valid, 1'b0);
    chk("abort_state", dut.div_state, 2'b00);
    chk("abort_cnt", dut.div_cnt, 5'd0);
    chk("abort_ms_valid", es_to_ms_valid, 1'b0);
    issue(mk(OP_ADD, 2'b00, 0, 0, 0, 0, 0, 1, 5'd11, 32'h0, 32'd1, 32'd2, 32'h1C00_0030));
    chk("post_add_valid", es_to_ms_valid, 1'b1);
    chk("post_add_result", es_to_ms_bus[63:32], 32'd3);

    // a fresh divide after the abort
    div_run(mk(12'h0, 2'b10, 0, 0, 0, 0, 0, 1, 5'd12, 32'h0, 32'd100, 32'd3, 32'h1C00_0034), 32'd33, "fresh_div", 1'b0);
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage in-order pipeline. Sits between decode (ds) and mem_stage.
- Takes decoded operands from ds and computes the ALU result or the multi-cycle divide/modulo result.
- Issues the data SRAM request for loads and stores, and hands the result bus to mem_stage.
- Drives a forwarding/stall bus back to ds.

Parameters:
- DS_TO_ES_BUS_WD, 153, width of decode-to-execute bus.
- ES_TO_MS_BUS_WD, 72, width of execute-to-mem bus.
- ES_TO_DS_BUS_WD, 39, width of forward bus to decode.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- ms_allowin  in  1  mem stage can accept.
- es_allowin  out  1  execute stage can accept.
- ds_to_es_valid  in  1  ds holds a valid instruction.
- ds_to_es_bus  in  153  MSB-first fields: alu_op[11:0], div_op[1:0] ({div,mod}), div_signed, load_op, store_op, src1_is_pc, src2_is_imm, gr_we, dest[4:0], imm[31:0], rj_value[31:0], rkd_value[31:0], pc[31:0].
- es_to_ms_valid  out  1  result valid toward mem stage.
- es_to_ms_bus  out  72  MSB-first: store_op, load_op, gr_we, dest[4:0], exe_result[31:0], pc[31:0].
- es_to_ds_forward_bus  out  39  MSB-first: dep_need_stall, forward_enable, dest[4:0], exe_result[31:0].
- es_to_ds_valid  out  1  equals es_valid.
- data_sram_en  out  1  SRAM access enable.
- data_sram_we  out  4  byte write enables.
- data_sram_addr  out  32  byte address.
- data_sram_wdata  out  32  store data.

Behaviour:
- **Pipeline handshake**
  - es_allowin = !es_valid | (es_ready_go & ms_allowin).
  - es_to_ms_valid = es_valid & es_ready_go.
  - On reset, es_valid is cleared. Otherwise, when es_allowin is 1, es_valid loads ds_to_es_valid.
  - The bus register loads ds_to_es_bus only when ds_to_es_valid & es_allowin.
- **Operand selection**
  - src1 = src1_is_pc ? pc : rj_value.
  - src2 = src2_is_imm ? imm : rkd_value.
- **ALU** (alu_op is one-hot; bit 0..11):
  - add, sub, slt (signed), sltu, and, nor, or, xor, sll, srl, sra, lui.
  - Shifts use src2[4:0]. lui returns src2.
  - All arithmetic is 32-bit wrap-around, with no overflow trap.
  - alu_op all-zero gives result 0.
- **Divider state machine** (div_op != 0): IDLE → BUSY → DONE → IDLE.
  - IDLE → BUSY: at the edge after es_valid & div_op!=0 is seen in IDLE. Latch operand magnitudes (absolute values when div_signed) and clear the 5-bit count.
  - BUSY: one restoring quotient bit per cycle. Count increments. On count == 31, go to DONE.
  - DONE: result held. es_ready_go = 1. On the edge where es_ready_go & ms_allowin, go to IDLE.
  - Sign fix: signed quotient is negated if the operand signs differ; signed remainder takes the dividend's sign.
  - Divisor 0: quotient 0xFFFFFFFF, remainder = src1 (signed and unsigned).
  - 0x80000000 / 0xFFFFFFFF signed: quotient 0x80000000, remainder 0.
  - exe_result = div ? quotient : (mod ? remainder : alu_result).
- **Timing**
  - Non-divide instructions: es_ready_go = 1, 1-cycle residency.
  - Divide: ready_go asserts in the 34th cycle of residency, counting the arrival cycle as 1.
- **Memory request**
  - data_sram_en = es_valid & es_ready_go & ms_allowin & (load_op | store_op), so the request fires only in the handoff cycle.
  - data_sram_we = 4'hF when en & store_op, else 0.
  - data_sram_addr = alu_result, word accesses only.
  - data_sram_wdata = rkd_value.
  - When ms_allowin = 0, en stays 0 and the bus holds stable.
- **Forwarding**
  - forward_enable = es_valid & gr_we & (dest != 0).
  - dep_need_stall = load_op | (div_op != 0 & state != DONE).
- **Reset values**: es_valid 0, divider state IDLE, count 0. All valid/enable outputs and data_sram_we are 0 during and after reset.
- **Reset mid-divide**: aborts to IDLE with es_valid 0. The next divide starts fresh.

Test Plan:
- **add**: add rj=5, rk=0xFFFFFFFF, dest=3 → next cycle es_to_ms_valid=1, exe_result=4, gr_we=1, forward_enable=1.
- **lui and sra**: lui imm=0x12345000 → result 0x12345000. sra rj=0x80000000, rk=4 → 0xF8000000.
- **store**: store rj=0x100, imm=8, rkd=0xDEADBEEF, ms_allowin=1 → en=1, we=F, addr=0x108, wdata=0xDEADBEEF for exactly one cycle.
- **backpressure**: ms_allowin=0 with a load resident → en=0, es_allowin=0, bus stable. Raise ms_allowin → one en pulse with we=0.
- **signed divide**: signed div -7/2 → q=0xFFFFFFFD. Signed mod → r=0xFFFFFFFF. es_to_ms_valid first high in cycle 34, and dep_need_stall=1 until then.
- **divide by zero and reset**: unsigned div 9/0 → 0xFFFFFFFF, mod → 9. Reset at BUSY count 10 → es_valid=0, state IDLE, and a following add completes in 1 cycle.
